sysctl: RTL

Clock, reset and front-panel input conditioning for the p601zero system, running entirely in the clk_in domain. It derives the CPU clock sys_clk from clk_in and sequences the system reset sys_res. It also synchronizes and debounces the push keys, produces the NMI request, and generates the 7-segment anode multiplex strobe. It feeds the top-level CPU/peripheral fabric.

---
 rtl/sysctl_pkg.sv | 30 +++
 rtl/sysctl_key_debounce.sv | 43 ++++
 rtl/sysctl.sv | 114 +++++++++++
 3 files changed

// File: rtl/sysctl_pkg.sv
// Shared constants, types and helpers for the p601zero system controller.
package sysctl_pkg;

    localparam int unsigned KEY_NMI = 2;

    localparam int unsigned DEF_OSC_CLOCK         = 12000000;
    localparam int unsigned DEF_CPU_CLOCK         = 3000000;
    localparam int unsigned DEF_LED_REFRESH_CLOCK = 50;

    typedef enum logic [1:0] {
        ANODE_D0 = 2'b01,
        ANODE_D1 = 2'b10
    } anode_e;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned half_div(input int unsigned osc, input int unsigned cpu);
        return osc / cpu / 2;
    endfunction

    function automatic int unsigned led_div(input int unsigned osc, input int unsigned refresh);
        return osc / refresh / 2;
    endfunction

    localparam int unsigned HALF = half_div(DEF_OSC_CLOCK, DEF_CPU_CLOCK);
    localparam int unsigned LDIV = led_div(DEF_OSC_CLOCK, DEF_LED_REFRESH_CLOCK);

endpackage

// File: rtl/sysctl_key_debounce.sv
// One push key: 2-FF synchronizer followed by a stability counter.
module key_debounce
    import sysctl_pkg::*;
#(
    parameter int unsigned TICKS = 120000
) (
    input  logic clk_in,
    input  logic b_reset,
    input  logic raw,
    output logic db
);

    localparam int unsigned      CNT_W    = clog2_safe(TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_stable_cnt;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_db         <= 1'b1;
            r_stable_cnt <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt == CNT_LAST) begin
                r_db         <= r_sync2;
                r_stable_cnt <= '0;
            end else begin
                r_stable_cnt <= r_stable_cnt + CNT_W'(1);
            end
        end
    end

    assign db = r_db;

endmodule

// File: rtl/sysctl.sv
// p601zero clock divider, reset sequencer, key conditioning, NMI and LED anode strobe.
module sysctl
    import sysctl_pkg::*;
#(
    parameter int unsigned OSC_CLOCK         = 12000000,
    parameter int unsigned CPU_CLOCK         = 3000000,
    parameter int unsigned LED_REFRESH_CLOCK = 50,
    parameter int unsigned RESET_CYCLES      = 4,
    parameter int unsigned DEBOUNCE_TICKS    = 120000
) (
    input  logic       clk_in,
    input  logic       b_reset,
    input  logic [2:0] keys_raw,
    input  logic       soft_reset_req,
    output logic       sys_clk,
    output logic       sys_clk_rise,
    output logic       sys_res,
    output logic [2:0] keys_db,
    output logic       nmi,
    output logic [1:0] led_anode
);

    localparam int unsigned      P_HALF   = half_div(OSC_CLOCK, CPU_CLOCK);
    localparam int unsigned      P_LDIV   = led_div(OSC_CLOCK, LED_REFRESH_CLOCK);
    localparam int unsigned      DIV_W    = clog2_safe(P_HALF);
    localparam int unsigned      LED_W    = clog2_safe(P_LDIV);
    localparam int unsigned      RES_W    = clog2_safe(RESET_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_HALF - 1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(P_LDIV - 1);
    localparam logic [RES_W-1:0] RES_LOAD = RES_W'(RESET_CYCLES);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sys_clk;
    logic             w_sys_clk_rise;
    logic [RES_W-1:0] r_res_cnt;
    logic             r_sys_res;
    logic [2:0]       w_keys_db;
    logic             r_nmi;
    logic [LED_W-1:0] r_led_cnt;
    anode_e           r_led_anode;

    assign w_sys_clk_rise = (r_div_cnt == DIV_LAST) && !r_sys_clk;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_div_cnt <= '0;
            r_sys_clk <= 1'b0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_sys_clk <= !r_sys_clk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // sys_res follows the count of the previous cycle, so it drops one clk_in after res_cnt hits 0.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_res_cnt <= RES_LOAD;
            r_sys_res <= 1'b1;
        end else begin
            r_sys_res <= (r_res_cnt != '0);
            if (w_sys_clk_rise) begin
                if (soft_reset_req) begin
                    r_res_cnt <= RES_LOAD;
                end else if (r_res_cnt != '0) begin
                    r_res_cnt <= r_res_cnt - RES_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_debounce #(
            .TICKS(DEBOUNCE_TICKS)
        ) u_key (
            .clk_in (clk_in),
            .b_reset(b_reset),
            .raw    (keys_raw[gi]),
            .db     (w_keys_db[gi])
        );
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_nmi <= 1'b0;
        end else begin
            r_nmi <= !w_keys_db[KEY_NMI] && !r_sys_res;
        end
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            r_led_cnt   <= '0;
            r_led_anode <= ANODE_D0;
        end else if (r_sys_res) begin
            r_led_cnt   <= '0;
            r_led_anode <= ANODE_D0;
        end else if (r_led_cnt == LED_LAST) begin
            r_led_cnt   <= '0;
            r_led_anode <= (r_led_anode == ANODE_D0) ? ANODE_D1 : ANODE_D0;
        end else begin
            r_led_cnt <= r_led_cnt + LED_W'(1);
        end
    end

    assign sys_clk      = r_sys_clk;
    assign sys_clk_rise = w_sys_clk_rise;
    assign sys_res      = r_sys_res;
    assign keys_db      = w_keys_db;
    assign nmi          = r_nmi;
    assign led_anode    = r_led_anode;

endmodule
